outvc_alloc_table: RTL and testbench



---
 rtl/outvc_alloc_table_pkg.sv | 39 +++
 rtl/outvc_alloc_table_entry.sv | 85 ++++++++
 rtl/outvc_alloc_table.sv | 112 +++++++++++
 tb/tb_outvc_alloc_table.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/outvc_alloc_table_pkg.sv
// Shared definitions for the output-VC allocation table and the update_release-side logic.
// Holds the VC state encoding, the credit-width check and small bit-vector helpers.
package outvc_alloc_table_pkg;

    typedef enum logic [1:0] {
        VC_FREE     = 2'd0,
        VC_ACTIVE   = 2'd1,
        VC_DRAINING = 2'd2
    } vc_state_e;

    // The credit counter must be able to hold buf_depth itself.
    function automatic bit credit_w_ok(input int unsigned depth, input int unsigned width);
        return (64'd1 << width) > 64'(depth);
    endfunction

    function automatic int unsigned onehot_to_index(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (vec[i]) idx = idx | i;
        end
        return idx;
    endfunction

    function automatic int unsigned lowest_set_bit(input logic [31:0] vec);
        int unsigned idx;
        bit          found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (vec[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/outvc_alloc_table_entry.sv
// One output VC: FREE/ACTIVE/DRAINING state machine, downstream credit counter and owner fields.
module outvc_entry
    import outvc_alloc_table_pkg::*;
#(
    parameter int unsigned buf_depth = 4,
    parameter int unsigned credit_w  = 3,
    parameter int unsigned port_w    = 3,
    parameter int unsigned vc_w      = 4
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              alloc,
    input  logic [port_w-1:0] alloc_port,
    input  logic [vc_w-1:0]   alloc_invc,
    input  logic              send,
    input  logic              send_tail,
    input  logic              credit_ret,
    output logic              busy,
    output logic              has_credit,
    output logic [port_w-1:0] owner_port,
    output logic [vc_w-1:0]   owner_invc,
    output logic              err
);

    localparam logic [credit_w-1:0] full = credit_w'(buf_depth);
    localparam logic [credit_w-1:0] one  = credit_w'(1);

    vc_state_e           state, state_nx;
    logic [credit_w-1:0] cnt, cnt_nx;
    logic                cnt_err, misuse;

    // A send and a return in the same cycle cancel, so neither bound is checked then.
    always_comb begin
        cnt_nx  = cnt;
        cnt_err = 1'b0;
        if (send && !credit_ret) begin
            if (cnt == '0) cnt_err = 1'b1;
            else           cnt_nx  = cnt - one;
        end else if (!send && credit_ret) begin
            if (cnt == full) cnt_err = 1'b1;
            else             cnt_nx  = cnt + one;
        end
    end

    always_comb begin
        state_nx = state;
        misuse   = 1'b0;
        case (state)
            VC_FREE: begin
                if (alloc) state_nx = VC_ACTIVE;
                if (send)  misuse   = 1'b1;
            end
            VC_ACTIVE: begin
                if (send && send_tail)
                    state_nx = (cnt_nx == full) ? VC_FREE : VC_DRAINING;
            end
            VC_DRAINING: begin
                if (cnt_nx == full) state_nx = VC_FREE;
                if (send)           misuse   = 1'b1;
            end
            default: state_nx = VC_FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state      <= VC_FREE;
            cnt        <= full;
            owner_port <= '0;
            owner_invc <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (alloc && state == VC_FREE) begin
                owner_port <= alloc_port;
                owner_invc <= alloc_invc;
            end
        end
    end

    assign busy       = (state != VC_FREE);
    assign has_credit = (cnt != '0);
    assign err        = cnt_err | misuse;

endmodule

// File: rtl/outvc_alloc_table.sv
// Per-output-port VC table: picks the lowest free allowed VC, registers the grant,
// and exposes busy tags, credit availability, owner lookup and a sticky error flag.
module outvc_alloc_table
    import outvc_alloc_table_pkg::*;
#(
    parameter int unsigned no_inport                   = 6,
    parameter int unsigned floorplusone_log2_no_inport = 3,
    parameter int unsigned no_vc                       = 13,
    parameter int unsigned floorplusone_log2_no_vc     = 4,
    parameter int unsigned buf_depth                   = 4,
    parameter int unsigned credit_w                    = 3
) (
    input  logic                                   clk,
    input  logic                                   rs,
    input  logic                                   update_en,
    input  logic [floorplusone_log2_no_vc-1:0]     vc_no,
    input  logic [no_vc-1:0]                       allowed_vcs,
    input  logic [no_inport-1:0]                   port_no_vec,
    input  logic                                   send_en,
    input  logic [floorplusone_log2_no_vc-1:0]     send_vc,
    input  logic                                   send_tail,
    input  logic [no_vc-1:0]                       credit_in,
    input  logic [floorplusone_log2_no_vc-1:0]     lookup_vc,
    output logic [no_vc-1:0]                       tags,
    output logic [no_vc-1:0]                       has_credit,
    output logic                                   grant_valid,
    output logic [floorplusone_log2_no_vc-1:0]     grant_outvc,
    output logic [floorplusone_log2_no_inport-1:0] grant_port,
    output logic                                   alloc_fail,
    output logic [floorplusone_log2_no_inport-1:0] lookup_port,
    output logic [floorplusone_log2_no_vc-1:0]     lookup_invc,
    output logic                                   credit_err
);

    localparam int unsigned port_w = floorplusone_log2_no_inport;
    localparam int unsigned vc_w   = floorplusone_log2_no_vc;

    if (!credit_w_ok(buf_depth, credit_w)) begin : g_bad_credit_w
        $error("credit_w too narrow to hold buf_depth");
    end

    logic [no_vc-1:0]  cand, alloc_vec, err_vec;
    logic              req_ok;
    logic [vc_w-1:0]   pick;
    logic [port_w-1:0] req_port;
    logic [port_w-1:0] owner_port [no_vc];
    logic [vc_w-1:0]   owner_invc [no_vc];

    assign cand     = allowed_vcs & ~tags;
    assign req_ok   = update_en && (cand != '0) && $onehot(port_no_vec);
    assign pick     = vc_w'(lowest_set_bit(32'(cand)));
    assign req_port = port_w'(onehot_to_index(32'(port_no_vec)));

    always_comb begin
        alloc_vec = '0;
        for (int unsigned v = 0; v < no_vc; v++) begin
            if (req_ok && pick == vc_w'(v)) alloc_vec[v] = 1'b1;
        end
    end

    for (genvar v = 0; v < no_vc; v++) begin : g_vc
        outvc_entry #(
            .buf_depth (buf_depth),
            .credit_w  (credit_w),
            .port_w    (port_w),
            .vc_w      (vc_w)
        ) u_entry (
            .clk        (clk),
            .rs         (rs),
            .alloc      (alloc_vec[v]),
            .alloc_port (req_port),
            .alloc_invc (vc_no),
            .send       (send_en && send_vc == vc_w'(v)),
            .send_tail  (send_tail),
            .credit_ret (credit_in[v]),
            .busy       (tags[v]),
            .has_credit (has_credit[v]),
            .owner_port (owner_port[v]),
            .owner_invc (owner_invc[v]),
            .err        (err_vec[v])
        );
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            grant_valid <= 1'b0;
            grant_outvc <= '0;
            grant_port  <= '0;
            alloc_fail  <= 1'b0;
            credit_err  <= 1'b0;
        end else begin
            grant_valid <= req_ok;
            grant_outvc <= req_ok ? pick : '0;
            grant_port  <= req_ok ? req_port : '0;
            alloc_fail  <= update_en && !req_ok;
            credit_err  <= credit_err | (|err_vec);
        end
    end

    // Addresses beyond no_vc read as zero.
    always_comb begin
        lookup_port = '0;
        lookup_invc = '0;
        for (int unsigned v = 0; v < no_vc; v++) begin
            if (lookup_vc == vc_w'(v)) begin
                lookup_port = owner_port[v];
                lookup_invc = owner_invc[v];
            end
        end
    end

endmodule

// File: tb/tb_outvc_alloc_table.sv
// Directed bench for outvc_alloc_table with hand-computed expectations checked by immediate assertions.
module tb_outvc_alloc_table;

    logic        clk = 1'b0;
    logic        rs;
    logic        update_en;
    logic [3:0]  vc_no;
    logic [12:0] allowed_vcs;
    logic [5:0]  port_no_vec;
    logic        send_en;
    logic [3:0]  send_vc;
    logic        send_tail;
    logic [12:0] credit_in;
    logic [3:0]  lookup_vc;
    logic [12:0] tags;
    logic [12:0] has_credit;
    logic        grant_valid;
    logic [3:0]  grant_outvc;
    logic [2:0]  grant_port;
    logic        alloc_fail;
    logic [2:0]  lookup_port;
    logic [3:0]  lookup_invc;
    logic        credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    outvc_alloc_table #(
        .no_inport                   (6),
        .floorplusone_log2_no_inport (3),
        .no_vc                       (13),
        .floorplusone_log2_no_vc     (4),
        .buf_depth                   (4),
        .credit_w                    (3)
    ) dut (
        .clk         (clk),
        .rs          (rs),
        .update_en   (update_en),
        .vc_no       (vc_no),
        .allowed_vcs (allowed_vcs),
        .port_no_vec (port_no_vec),
        .send_en     (send_en),
        .send_vc     (send_vc),
        .send_tail   (send_tail),
        .credit_in   (credit_in),
        .lookup_vc   (lookup_vc),
        .tags        (tags),
        .has_credit  (has_credit),
        .grant_valid (grant_valid),
        .grant_outvc (grant_outvc),
        .grant_port  (grant_port),
        .alloc_fail  (alloc_fail),
        .lookup_port (lookup_port),
        .lookup_invc (lookup_invc),
        .credit_err  (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        update_en = 1'b0;
        send_en   = 1'b0;
        send_tail = 1'b0;
        credit_in = '0;
    endtask

    task automatic request(input logic [12:0] allow, input logic [5:0] port, input logic [3:0] vc);
        update_en   = 1'b1;
        allowed_vcs = allow;
        port_no_vec = port;
        vc_no       = vc;
    endtask

    task automatic send(input logic [3:0] vc, input logic tail);
        send_en   = 1'b1;
        send_vc   = vc;
        send_tail = tail;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rs = 1'b1;
        idle();
        vc_no = '0; allowed_vcs = '0; port_no_vec = '0; send_vc = '0; lookup_vc = '0;
        tick(); tick();
        chk("rst_tags", 32'(tags), 32'h0);
        chk("rst_has_credit", 32'(has_credit), 32'h1FFF);
        chk("rst_grant_valid", 32'(grant_valid), 32'h0);
        chk("rst_alloc_fail", 32'(alloc_fail), 32'h0);
        chk("rst_credit_err", 32'(credit_err), 32'h0);
        rs = 1'b0;
        tick();

        // Step 1: first grant lands on VC2
        request(13'h00C, 6'b000100, 4'd5);
        tick(); idle();
        lookup_vc = 4'd2; #1;
        chk("s1_grant_valid", 32'(grant_valid), 32'h1);
        chk("s1_grant_outvc", 32'(grant_outvc), 32'h2);
        chk("s1_grant_port", 32'(grant_port), 32'h2);
        chk("s1_tags", 32'(tags), 32'h004);
        chk("s1_lookup_port", 32'(lookup_port), 32'h2);
        chk("s1_lookup_invc", 32'(lookup_invc), 32'h5);
        tick();
        chk("s1_grant_pulse", 32'(grant_valid), 32'h0);

        // Step 2: second grant VC3, third request fails
        request(13'h00C, 6'b000100, 4'd5);
        tick(); idle();
        chk("s2_grant_outvc", 32'(grant_outvc), 32'h3);
        chk("s2_tags", 32'(tags), 32'h00C);
        request(13'h00C, 6'b000100, 4'd5);
        tick(); idle();
        chk("s2_fail", 32'(alloc_fail), 32'h1);
        chk("s2_fail_no_grant", 32'(grant_valid), 32'h0);
        chk("s2_fail_tags", 32'(tags), 32'h00C);
        request(13'h1FFF, 6'b000110, 4'd1);
        tick(); idle();
        chk("s2_nonhot_fail", 32'(alloc_fail), 32'h1);
        chk("s2_nonhot_tags", 32'(tags), 32'h00C);
        request(13'h1FFF, 6'b000000, 4'd1);
        tick(); idle();
        chk("s2_zero_port_fail", 32'(alloc_fail), 32'h1);
        tick();
        chk("s2_fail_pulse", 32'(alloc_fail), 32'h0);

        // Step 3: drain VC2 and return its credits
        send(4'd2, 1'b0);
        tick(); tick(); tick();
        chk("s3_credit_left", 32'(has_credit), 32'h1FFF);
        send(4'd2, 1'b1);
        tick(); idle();
        chk("s3_draining_tags", 32'(tags), 32'h00C);
        chk("s3_no_credit", 32'(has_credit), 32'h1FFB);
        chk("s3_no_err", 32'(credit_err), 32'h0);
        credit_in = 13'h004;
        tick(); tick(); tick();
        chk("s3_still_draining", 32'(tags), 32'h00C);
        tick(); idle();
        chk("s3_freed", 32'(tags), 32'h008);
        chk("s3_credit_back", 32'(has_credit), 32'h1FFF);
        chk("s3_owner_kept", 32'(lookup_invc), 32'h5);

        // Freed VC2 reallocated to a new owner
        request(13'h00C, 6'b000001, 4'd9);
        tick(); idle(); #1;
        chk("s3_realloc_outvc", 32'(grant_outvc), 32'h2);
        chk("s3_realloc_port", 32'(grant_port), 32'h0);
        chk("s3_realloc_lookup_port", 32'(lookup_port), 32'h0);
        chk("s3_realloc_lookup_invc", 32'(lookup_invc), 32'h9);

        // Step 4: single-flit packet, tail and credit in the same cycle
        send(4'd2, 1'b1);
        credit_in = 13'h004;
        tick(); idle();
        chk("s4_direct_free", 32'(tags), 32'h008);
        chk("s4_credit_full", 32'(has_credit), 32'h1FFF);
        chk("s4_no_err", 32'(credit_err), 32'h0);

        // Step 5a: credit return at full count is an error and sticky
        credit_in = 13'h001;
        tick(); idle();
        chk("s5_overflow_err", 32'(credit_err), 32'h1);
        chk("s5_overflow_sat", 32'(has_credit), 32'h1FFF);
        tick(); tick();
        chk("s5_err_sticky", 32'(credit_err), 32'h1);
        rs = 1'b1; #1;
        chk("s5_rst_err", 32'(credit_err), 32'h0);
        chk("s5_rst_tags", 32'(tags), 32'h0);
        tick();
        rs = 1'b0;
        tick();

        // Step 5b: send at zero credits on an active VC7
        request(13'h080, 6'b100000, 4'd12);
        tick(); idle();
        chk("s5_vc7_outvc", 32'(grant_outvc), 32'h7);
        chk("s5_vc7_port", 32'(grant_port), 32'h5);
        chk("s5_vc7_tags", 32'(tags), 32'h080);
        send(4'd7, 1'b0);
        tick(); tick(); tick(); tick(); idle();
        chk("s5_vc7_empty", 32'(has_credit), 32'h1F7F);
        chk("s5_vc7_no_err_yet", 32'(credit_err), 32'h0);
        send(4'd7, 1'b0);
        tick(); idle();
        chk("s5_underflow_err", 32'(credit_err), 32'h1);
        chk("s5_underflow_held", 32'(has_credit), 32'h1F7F);

        // Step 5c: VC7 into DRAINING with a grant pending, then async reset
        credit_in = 13'h080;
        tick(); idle();
        send(4'd7, 1'b1);
        request(13'h001, 6'b000001, 4'd1);
        tick(); idle();
        lookup_vc = 4'd0;
        chk("s5_pre_rst_tags", 32'(tags), 32'h081);
        chk("s5_pre_rst_grant", 32'(grant_valid), 32'h1);
        #2 rs = 1'b1;
        #1;
        chk("s5_rst_tags_async", 32'(tags), 32'h0);
        chk("s5_rst_credit", 32'(has_credit), 32'h1FFF);
        chk("s5_rst_grant_valid", 32'(grant_valid), 32'h0);
        chk("s5_rst_grant_outvc", 32'(grant_outvc), 32'h0);
        chk("s5_rst_credit_err", 32'(credit_err), 32'h0);
        chk("s5_rst_owner_invc", 32'(lookup_invc), 32'h0);
        tick();
        rs = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
